// File: rtl/rr_mux_pkg.sv
// Shared defaults and pointer helper for the round-robin registered mux.
package rr_mux_pkg;

  localparam int RR_N_DEF = 8;
  localparam int RR_W_DEF = 8;

  // Mod-n increment of the round-robin pointer.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: first requester at or after ptr wins,
// unless lock pins the grant to lock_idx.
module rr_arbiter #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 lock,
  input  logic [$clog2(N)-1:0] lock_idx,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int SW = $clog2(N);

  logic          found;
  logic [SW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    if (lock) begin
      if (req[lock_idx]) begin
        gnt[lock_idx] = 1'b1;
        gnt_idx       = lock_idx;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = SW'((int'(ptr) + k) % N);
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          gnt_idx  = idx;
        end
      end
    end
  end

endmodule

// File: rtl/rr_mux_n.sv
// N-channel registered mux with round-robin arbitration and valid/ready on all sides.
// Define RR_MUX_LOCK_EN to add in_last and hold the grant until a packet's last beat.
module rr_mux_n
  import rr_mux_pkg::*;
#(
  parameter int N = RR_N_DEF,
  parameter int W = RR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*W-1:0]       in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
`ifdef RR_MUX_LOCK_EN
  input  logic [N-1:0]         in_last,
`endif
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int SW = $clog2(N);

  logic [SW-1:0] ptr;
  logic [SW-1:0] ptr_next;
  logic [SW-1:0] gnt_idx;
  logic [N-1:0]  gnt;
  logic [W-1:0]  sel_data;
  logic          load;
  logic          accept;
  logic          locked;
  logic [SW-1:0] lock_idx;

  rr_arbiter #(.N(N)) u_arb (
    .req      (in_valid),
    .ptr      (ptr),
    .lock     (locked),
    .lock_idx (lock_idx),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx)
  );

  // Ready is held low during reset so no source believes a beat was taken.
  assign load     = !out_valid || out_ready;
  assign accept   = load && (|gnt) && !rst;
  assign in_ready = accept ? gnt : '0;
  assign ptr_next = SW'(rr_next(int'(gnt_idx), N));

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) sel_data = sel_data | in_data[i*W +: W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= gnt_idx;
`ifdef RR_MUX_LOCK_EN
      if (in_last[gnt_idx]) ptr <= ptr_next;
`else
      ptr       <= ptr_next;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef RR_MUX_LOCK_EN
  // A non-last beat pins the grant to its channel until that channel sends last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked   <= 1'b0;
      lock_idx <= '0;
    end else if (accept) begin
      locked   <= !in_last[gnt_idx];
      lock_idx <= gnt_idx;
    end
  end
`else
  assign locked   = 1'b0;
  assign lock_idx = '0;
`endif

endmodule
